// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB low/full-speed transmit path.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    STUFF,
    EOP,
    EOP_J
  } tx_state_e;

  localparam logic LINE_J = 1'b1;
  localparam logic LINE_K = 1'b0;

  localparam int unsigned STUFF_LEN_DEF      = 6;
  localparam int unsigned EOP_SE0_CYCLES_DEF = 2;

endpackage

// File: rtl/usb_bit_stuff.sv
// Ones counter for USB bit stuffing; flags the accept that completes a run of STUFF_LEN ones.
module usb_bit_stuff
  import usb_tx_pkg::*;
#(
  parameter int unsigned STUFF_LEN = STUFF_LEN_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic accept_i,
  input  logic data_i,
  input  logic clear_i,
  output logic stuff_due_c_o
);

  localparam int unsigned CNT_W = $clog2(STUFF_LEN + 1);

  logic [CNT_W-1:0] ones_q, ones_d;

  always_comb begin
    ones_d = ones_q;
    if (clear_i) begin
      ones_d = '0;
    end else if (accept_i) begin
      ones_d = data_i ? ones_q + 1'b1 : '0;
    end
  end

  // Combinational so the encoder can drop o_ready for the very next cycle.
  assign stuff_due_c_o = accept_i && data_i && (ones_q == CNT_W'(STUFF_LEN - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ones_q <= '0;
    end else begin
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/nrzi_encode.sv
// USB transmit line encoder: bit stuffing, NRZI encoding and SE0/J end-of-packet.
module nrzi_encode
  import usb_tx_pkg::*;
#(
  parameter int unsigned STUFF_LEN      = STUFF_LEN_DEF,
  parameter int unsigned EOP_SE0_CYCLES = EOP_SE0_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_data,
  input  logic i_valid,
  input  logic i_last,
  output logic o_ready,
  output logic o_nrzi,
  output logic o_se0,
  output logic o_valid,
  output logic o_underrun
);

  localparam int unsigned EOP_CNT_W = (EOP_SE0_CYCLES > 1) ? $clog2(EOP_SE0_CYCLES) : 1;

  tx_state_e            state_q, state_d;
  logic                 line_q, line_d;
  logic                 last_q, last_d;
  logic [EOP_CNT_W-1:0] eop_cnt_q, eop_cnt_d;
  logic                 nrzi_q, nrzi_d;
  logic                 se0_q, se0_d;
  logic                 valid_q, valid_d;
  logic                 underrun_q, underrun_d;
  logic                 ready_q, ready_d;

  logic accept_c;
  logic stuff_due_c;
  logic clear_c;
  logic line_next_c;

  assign accept_c    = i_valid && ready_q;
  assign line_next_c = i_data ? line_q : ~line_q;

  usb_bit_stuff #(
    .STUFF_LEN(STUFF_LEN)
  ) u_bit_stuff (
    .clk_i        (i_clk),
    .rst_i        (i_rst),
    .accept_i     (accept_c),
    .data_i       (i_data),
    .clear_i      (clear_c),
    .stuff_due_c_o(stuff_due_c)
  );

  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    last_d     = last_q;
    eop_cnt_d  = eop_cnt_q;
    nrzi_d     = LINE_J;
    se0_d      = 1'b0;
    valid_d    = 1'b0;
    underrun_d = 1'b0;
    clear_c    = 1'b0;

    unique case (state_q)
      IDLE, DATA: begin
        if (accept_c) begin
          line_d    = line_next_c;
          nrzi_d    = line_next_c;
          valid_d   = 1'b1;
          last_d    = i_last;
          eop_cnt_d = '0;
          if (stuff_due_c) begin
            state_d = STUFF;
          end else if (i_last) begin
            state_d = EOP;
          end else begin
            state_d = DATA;
          end
        end else if (state_q == DATA) begin
          // Missing mid-packet bit: hold line and counter, flag upstream.
          nrzi_d     = line_q;
          underrun_d = 1'b1;
        end
      end
      STUFF: begin
        line_d    = ~line_q;
        nrzi_d    = ~line_q;
        valid_d   = 1'b1;
        clear_c   = 1'b1;
        eop_cnt_d = '0;
        state_d   = last_q ? EOP : DATA;
      end
      EOP: begin
        se0_d   = 1'b1;
        valid_d = 1'b1;
        clear_c = 1'b1;
        if (eop_cnt_q == EOP_CNT_W'(EOP_SE0_CYCLES - 1)) begin
          state_d = EOP_J;
        end else begin
          eop_cnt_d = eop_cnt_q + 1'b1;
        end
      end
      EOP_J: begin
        nrzi_d  = LINE_J;
        valid_d = 1'b1;
        line_d  = LINE_J;
        last_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Ready stays low while the J bit is on the line; it returns on the idle cycle.
    ready_d = (state_d == DATA) || ((state_d == IDLE) && (state_q == IDLE));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      line_q     <= LINE_J;
      last_q     <= 1'b0;
      eop_cnt_q  <= '0;
      nrzi_q     <= LINE_J;
      se0_q      <= 1'b0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      last_q     <= last_d;
      eop_cnt_q  <= eop_cnt_d;
      nrzi_q     <= nrzi_d;
      se0_q      <= se0_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
      ready_q    <= ready_d;
    end
  end

  assign o_ready    = ready_q;
  assign o_nrzi     = nrzi_q;
  assign o_se0      = se0_q;
  assign o_valid    = valid_q;
  assign o_underrun = underrun_q;

endmodule

// File: tb/tb_nrzi_encode.sv
// Bench for nrzi_encode: directed and random packets against a line-stream reference model.
module tb_nrzi_encode;

  logic i_clk;
  logic i_rst;
  logic i_data;
  logic i_valid;
  logic i_last;
  logic o_ready;
  logic o_nrzi;
  logic o_se0;
  logic o_valid;
  logic o_underrun;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected line stream per bit-time: 2'b10 = SE0, otherwise {0, level}.
  bit [1:0] exp_q[$];
  int       exp_mid_stuffs;

  nrzi_encode dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .i_last    (i_last),
    .o_ready   (o_ready),
    .o_nrzi    (o_nrzi),
    .o_se0     (o_se0),
    .o_valid   (o_valid),
    .o_underrun(o_underrun)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: insert a 0 after every six consecutive 1s, NRZI from J, then SE0,SE0,J.
  function automatic void build_model(input bit bits[$]);
    bit line;
    int ones;
    line = 1'b1;
    ones = 0;
    exp_mid_stuffs = 0;
    exp_q.delete();
    for (int i = 0; i < bits.size(); i++) begin
      if (!bits[i]) line = ~line;
      exp_q.push_back({1'b0, line});
      ones = bits[i] ? ones + 1 : 0;
      if (ones == 6) begin
        line = ~line;
        exp_q.push_back({1'b0, line});
        ones = 0;
        if (i != bits.size() - 1) exp_mid_stuffs++;
      end
    end
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
  endfunction

  task automatic run_packet(input string name, input bit bits[$], input int gap_at, input int gap_len);
    bit [1:0] got[$];
    int n, idx, gap_left, cyc;
    int under, bad_under, invalid_mid, ready_low_mid;
    bit started, saw_se0, saw_j, done;
    n = bits.size();
    idx = 0; gap_left = gap_len; cyc = 0;
    under = 0; bad_under = 0; invalid_mid = 0; ready_low_mid = 0;
    started = 0; saw_se0 = 0; saw_j = 0; done = 0;
    build_model(bits);
    while (!done && cyc < 400) begin
      @(negedge i_clk);
      cyc++;
      if (o_underrun) under++;
      if (o_underrun && o_valid) bad_under++;
      if (saw_j) begin
        check({name, "/idle_valid"}, 32'(o_valid), 32'd0);
        check({name, "/idle_ready"}, 32'(o_ready), 32'd1);
        done = 1;
      end else if (o_valid) begin
        started = 1;
        got.push_back(o_se0 ? 2'b10 : {1'b0, o_nrzi});
        if (o_se0) saw_se0 = 1;
        else if (saw_se0) begin
          saw_j = 1;
          check({name, "/j_ready"}, 32'(o_ready), 32'd0);
        end
      end else if (started) begin
        invalid_mid++;
      end
      if (idx > 0 && idx < n && !o_ready) ready_low_mid++;
      if (idx < n && !done) begin
        if (idx == gap_at && gap_left > 0) begin
          i_valid = 1'b0;
          i_last  = 1'b0;
          if (o_ready) gap_left--;
        end else begin
          i_valid = 1'b1;
          i_data  = bits[idx];
          i_last  = (idx == n - 1);
          if (o_ready) idx++;
        end
      end else begin
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_data  = 1'b0;
      end
    end
    check({name, "/finished"}, 32'(done), 32'd1);
    check({name, "/len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s/bit%0d", name, i), 32'(got[i]), 32'(exp_q[i]));
    check({name, "/underruns"}, 32'(under), 32'(gap_len));
    check({name, "/underrun_valid"}, 32'(bad_under), 32'd0);
    check({name, "/holes"}, 32'(invalid_mid), 32'(gap_len));
    check({name, "/stuff_ready_low"}, 32'(ready_low_mid), 32'(exp_mid_stuffs));
  endtask

  initial begin
    bit pkt[$];
    int n, ga, gl;

    i_rst = 1'b1; i_data = 1'b0; i_valid = 1'b0; i_last = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst/nrzi", 32'(o_nrzi), 32'd1);
    check("rst/se0", 32'(o_se0), 32'd0);
    check("rst/valid", 32'(o_valid), 32'd0);
    check("rst/ready", 32'(o_ready), 32'd0);
    check("rst/underrun", 32'(o_underrun), 32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("rst/ready_rise", 32'(o_ready), 32'd1);

    pkt = '{0, 0, 1, 1};
    run_packet("p0011", pkt, -1, 0);
    pkt = '{1, 1, 1, 1, 1, 1, 1, 0};
    run_packet("seven1", pkt, -1, 0);
    pkt = '{1, 1, 1, 1, 1, 1};
    run_packet("six1last", pkt, -1, 0);
    pkt = '{1, 1, 1, 1, 1, 1, 0};
    run_packet("underrun", pkt, 3, 2);

    // Reset while SE0 is on the line.
    pkt = '{1, 0, 1};
    for (int i = 0; i < pkt.size(); i++) begin
      i_valid = 1'b1; i_data = pkt[i]; i_last = (i == pkt.size() - 1);
      @(negedge i_clk);
    end
    i_valid = 1'b0; i_last = 1'b0;
    @(negedge i_clk);
    check("eop/se0_seen", 32'(o_se0), 32'd1);
    #1 i_rst = 1'b1;
    #1;
    check("eop_rst/nrzi", 32'(o_nrzi), 32'd1);
    check("eop_rst/se0", 32'(o_se0), 32'd0);
    check("eop_rst/valid", 32'(o_valid), 32'd0);
    check("eop_rst/ready", 32'(o_ready), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    pkt = '{0, 1, 1, 1, 1, 1, 1, 0};
    run_packet("after_rst", pkt, -1, 0);

    for (int p = 0; p < 10; p++) begin
      pkt.delete();
      n = $urandom_range(1, 30);
      for (int i = 0; i < n; i++) pkt.push_back($urandom_range(0, 3) != 0);
      if (n > 1 && $urandom_range(0, 1) == 1) begin
        ga = $urandom_range(1, n - 1);
        gl = $urandom_range(1, 3);
      end else begin
        ga = -1;
        gl = 0;
      end
      run_packet($sformatf("rnd%0d", p), pkt, ga, gl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nrzi_encode.md
# nrzi_encode

USB low/full-speed transmit line encoder: the transmit-side counterpart of the NRZI decode path in the usb_decode area. It accepts raw packet bits from the packetiser over a valid/ready handshake, performs USB bit stuffing and NRZI encoding, and appends the SE0/J end-of-packet sequence. Output drives the transceiver interface at one line bit per clock.

## Interface
- STUFF_LEN, 6: consecutive data 1s that force insertion of a stuff 0.
- EOP_SE0_CYCLES, 2: SE0 bit-times in the end-of-packet sequence.

- i_clk, input, 1: bit-rate clock.
- i_rst, input, 1: reset; one clock; reset is asynchronous and active-high.
- i_data, input, 1: raw packet bit, SYNC and PID included, LSB-first order already applied.
- i_valid, input, 1: i_data/i_last valid.
- i_last, input, 1: current bit is the final bit of the packet.
- o_ready, output, 1: encoder accepts a bit this cycle.
- o_nrzi, output, 1: encoded line level; 1 = J.
- o_se0, output, 1: drive SE0; o_nrzi is don't-care while high.
- o_valid, output, 1: o_nrzi/o_se0 carry a bit-time this cycle.
- o_underrun, output, 1: one-cycle pulse when a mid-packet bit is missing.

## Operation
- A transfer occurs when i_valid && o_ready.
- NRZI: bit 0 toggles the line; bit 1 holds it. Line state starts at J (1) for every packet.
- Stuffing: the ones counter increments on each accepted 1 and clears on any 0 (data or stuff). When it reaches STUFF_LEN, the next bit-time is a stuff 0 (toggle). o_ready is low for that cycle and the counter clears. Stuffing applies to the final data bit too.
- States:
  - IDLE: o_ready=1. The first transfer enters DATA and clears the counter.
  - DATA: o_ready=1 unless a stuff is pending.
  - STUFF: one cycle. Returns to DATA, or to EOP if the bit before it was last.
  - EOP: o_se0=1 for EOP_SE0_CYCLES.
  - EOP_J: one cycle with o_nrzi=1 and o_se0=0, then IDLE.
- After accepting a bit with i_last: go to STUFF if a stuff is due, else go to EOP. o_ready=0 throughout STUFF, EOP and EOP_J.
- Underrun: in DATA with no stuff pending and i_valid=0:
  - o_valid=0 and o_underrun=1 for that cycle.
  - Line level and ones counter hold; the state stays DATA.
  - The upstream block is responsible for aborting the packet.
- IDLE outputs: o_valid=0, o_nrzi=1, o_se0=0.

## Timing
- All outputs are registered.
- Reset values: o_nrzi=1, o_se0=0, o_valid=0, o_underrun=0, o_ready=0. State is IDLE and the counter is 0.
- o_ready rises the first clock after reset deasserts.
- Latency: a bit accepted at edge k appears on o_nrzi/o_valid after edge k, i.e. during cycle k+1.
- Throughput: one line bit per cycle. Each stuff bit costs exactly one ready-low cycle.
- Packet tail with no stuff: last data bit, then EOP_SE0_CYCLES of SE0, then one J cycle, then idle with o_valid=0. o_ready returns high on the idle cycle.
- Asserting reset mid-packet forces the reset values immediately and asynchronously. No EOP is emitted.

## Structure
- Package usb_tx_pkg holds:
  - the state enum (IDLE, DATA, STUFF, EOP, EOP_J);
  - line-level constants LINE_J=1 and LINE_K=0;
  - default stuff length and EOP length.
- One natural sub-module, usb_bit_stuff: the ones counter plus stuff-pending flag, with inputs accept, data and clear, and output stuff_due. The encoder FSM and NRZI flop live in the top.

## Test plan
- Reset: hold i_rst high → o_nrzi=1, o_valid=0, o_se0=0, o_ready=0. Release → o_ready=1 next cycle.
- Bits 0,0,1,1 (last on the final 1) → o_nrzi 0,1,1,1 on consecutive cycles, then o_se0=1 for 2 cycles, then o_nrzi=1/o_se0=0 for 1 cycle, then o_valid=0.
- Seven 1s, then a last 0 → o_nrzi 1,1,1,1,1,1,0(stuff),0,1. o_ready is low exactly on the cycle after the sixth 1 is accepted.
- Six 1s with i_last on the sixth → six 1s, then stuff 0, then SE0,SE0,J. No bit is lost or duplicated.
- i_valid dropped for 2 cycles mid-packet, with 3 ones accumulated → o_underrun pulses each cycle and o_valid=0. Resuming with 1,1,1 produces a stuff bit after the third, confirming the counter was held.
- i_rst asserted during the EOP state → outputs return to their reset values immediately. After release, a new packet starts from J with the counter at 0.
